dmem_requester: RTL and testbench

DMEM_REQUESTER -- requirements
Module: dmem_requester

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/byte_lane_unit.sv | 60 ++++++
 rtl/dmem_requester.sv | 140 ++++++++++++++
 tb/tb_dmem_requester.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory requester.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, RISC-V load/store width codes, invalid-op decode.
// Misaligned-access faults are handled in dmem_requester under MISALIGN_TRAP_EN.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    WRH  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Unsupported width codes, and unsigned variants used with a store.
  function automatic logic is_invalid_op(input logic is_store, input logic [2:0] funct3);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Load lane extract/extend and sub-word store merge for one 32-bit RAM word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports: funct3 (width code), offset (byte address bits [1:0]), rdata (RAM word),
//        wdata (store operand), load_ext (extended load result), merged (word to write).
module byte_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    // Halfword lane follows addr[1] only; an odd address is not trapped here.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    load_ext = rdata;
    case (funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {24'h000000, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {16'h0000, half_sel};
      default: load_ext = rdata;
    endcase

    merged = rdata;
    case (funct3[1:0])
      2'b00: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_requester.sv
// Sequences one CPU load/store onto a single-port synchronous RAM (read-modify-write for B/H stores).
// Latency: done 3 cycles after accept for loads and SW, 5 for SB/SH, 1 for faults.
// Backpressure: busy stalls the CPU while not IDLE; req is only sampled in IDLE.
//
// Ports: clk, nRst (async active-low); CPU side req/is_store/funct3/addr/store_data in,
//        load_data/busy/done/err out; RAM side read_enable/write_enable/address_DM/data_in out,
//        data_out in (valid the cycle after read_enable).
// Build option: define MISALIGN_TRAP_EN to fault misaligned H/HU/SH and W/SW accesses.
module dmem_requester
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        read_enable,
  output logic        write_enable,
  output logic [11:0] address_DM,
  output logic [31:0] data_in,
  input  logic [31:0] data_out
);

  state_t      state, state_nxt;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;     // store operand, replaced by the merged word in CAP
  logic        err_q;
  logic        accept;
  logic        fault;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  // The RAM only spans 4 KiB; the upper address bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:12];

  assign accept = (state == IDLE) && req;

  always_comb begin
    fault = is_invalid_op(is_store, funct3);
`ifdef MISALIGN_TRAP_EN
    if ((funct3[1:0] == 2'b01) && addr[0]) fault = 1'b1;
    if ((funct3 == F3_W) && (addr[1:0] != 2'b00)) fault = 1'b1;
`endif
  end

  byte_lane_unit u_lane (
    .funct3   (funct3_q),
    .offset   (addr_q[1:0]),
    .rdata    (data_out),
    .wdata    (wdata_q),
    .load_ext (lane_load),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address_DM   = {addr_q[11:2], 2'b00};
    data_in      = '0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        address_DM = '0;
        if (req) begin
          if (fault)                            state_nxt = DONE;
          else if (is_store && funct3 == F3_W)  state_nxt = WR;
          else                                  state_nxt = RD;
        end
      end
      RD: begin
        read_enable = 1'b1;
        state_nxt   = CAP;
      end
      CAP: begin
        state_nxt = is_store_q ? WR : DONE;
      end
      WR: begin
        write_enable = 1'b1;
        data_in      = wdata_q;
        state_nxt    = WRH;
      end
      WRH: begin
        state_nxt = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = err_q;
        address_DM = '0;
        state_nxt  = IDLE;
      end
      default: begin
        busy       = 1'b0;
        address_DM = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      load_data  <= '0;
    end else begin
      if (accept) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr[11:0];
        wdata_q    <= store_data;
        err_q      <= fault;
      end
      if (state == CAP) begin
        if (is_store_q) wdata_q   <= lane_merged;
        else            load_data <= lane_load;
      end
    end
  end

endmodule

// File: tb/tb_dmem_requester.sv
// Self-checking bench for dmem_requester: directed vectors plus randomized ops vs. a behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dmem_requester;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        busy, done, err, read_enable, write_enable;
  logic [11:0] address_DM;
  logic [31:0] data_in;
  logic [31:0] data_out = '0;

  dmem_requester dut (
    .clk(clk), .nRst(nRst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .busy(busy),
    .done(done), .err(err), .read_enable(read_enable), .write_enable(write_enable),
    .address_DM(address_DM), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with a bench-side preload port.
  logic [31:0] mem [0:1023];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;
  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (write_enable) mem[address_DM[11:2]] <= data_in;
    if (read_enable) data_out <= mem[address_DM[11:2]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: expected RAM contents (low 64 words) and expected load_data.
  logic [31:0] shadow [0:63];
  logic [31:0] m_load = '0;

  typedef struct {
    int          done_cyc;
    int          wr_cyc;
    bit          err;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] wr_word;
    logic [31:0] load;
    logic [11:0] rd_addr;
    logic [11:0] wr_addr;
    bit          busy_ok;
    bit          idle_after;
  } res_t;

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = 10'(idx); tb_wd = val;
    @(posedge clk); #1;
    tb_we = 1'b0;
    shadow[idx] = val;
  endtask

  // Architectural model: what a load/store does to memory and load_data, and its timing.
  task automatic model_step(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, output res_t e);
    int size, sh, idx;
    bit bad;
    logic [31:0] w, ld, mask;
    e = '{default: '0};
    idx  = int'(a[7:2]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad  = (f3[1:0] == 2'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
`ifdef MISALIGN_TRAP_EN
    if (size > 1 && (a & (size - 1)) != 0) bad = 1'b1;
`endif
    e.rd_addr = {a[11:2], 2'b00};
    e.wr_addr = {a[11:2], 2'b00};
    w  = shadow[idx];
    sh = (size == 1) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (bad) begin
      e.done_cyc = 1; e.err = 1'b1;
    end else if (!st) begin
      e.done_cyc = 3; e.rd_cnt = 1;
      if (size == 4) ld = w;
      else begin
        ld = (w >> sh) & mask;
        if (!f3[2] && ld[8 * size - 1]) ld = ld | ~mask;
      end
      m_load = ld;
    end else if (size == 4) begin
      e.done_cyc = 3; e.wr_cnt = 1; e.wr_cyc = 1; e.wr_word = sd;
      shadow[idx] = sd;
    end else begin
      e.done_cyc = 5; e.rd_cnt = 1; e.wr_cnt = 1; e.wr_cyc = 3;
      e.wr_word = (w & ~(mask << sh)) | ((sd << sh) & (mask << sh));
      shadow[idx] = e.wr_word;
    end
    e.load = m_load;
    e.busy_ok = 1'b1;
    e.idle_after = 1'b1;
  endtask

  // Drives one request, scrambles the inputs after accept, and records what the DUT did.
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, output res_t o);
    bit fin;
    fin = 1'b0;
    o = '{default: '0};
    o.busy_ok = 1'b1;
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    is_store = 1'($urandom()); funct3 = 3'($urandom()); addr = $urandom(); store_data = $urandom();
    for (int c = 1; c <= 12 && !fin; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) o.busy_ok = 1'b0;
      if (read_enable === 1'b1) begin o.rd_cnt++; o.rd_addr = address_DM; end
      if (write_enable === 1'b1) begin
        o.wr_cnt++; o.wr_cyc = c; o.wr_word = data_in; o.wr_addr = address_DM;
      end
      if (done === 1'b1) begin
        o.done_cyc = c; o.err = err; o.load = load_data; fin = 1'b1;
      end
    end
    req = 1'b0;
    @(negedge clk);
    o.idle_after = (busy === 1'b0) && (done === 1'b0);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({busy, done, err, read_enable, write_enable} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 00000", {busy, done, err, read_enable, write_enable});
    end
    n_cmp++; if (load_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_load_data: got %h required 00000000", load_data);
    end
    n_cmp++; if ({address_DM, data_in} !== 44'h0) begin
      n_bad++; $display("FAIL reset_ram_bus: got addr %h data %h required 0", address_DM, data_in);
    end
    @(negedge clk);
    nRst = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, $urandom());
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{F3_B, F3_BU, F3_HU, F3_H};
    logic [31:0] as  [4] = '{32'h40, 32'h43, 32'h42, 32'h42};
    logic [31:0] exp [4] = '{32'hFFFFFFF1, 32'h00000087, 32'h00008765, 32'hFFFF8765};
    res_t e, o;
    poke(16, 32'h876543F1);
    for (int i = 0; i < 4; i++) begin
      model_step(1'b0, f3s[i], as[i], 32'h0, e);
      do_access(1'b0, f3s[i], as[i], 32'h0, o);
      n_cmp++; if (o.load !== exp[i]) begin
        n_bad++; $display("FAIL load_val[%0d]: got %h required %h", i, o.load, exp[i]);
      end
      n_cmp++; if (o.done_cyc !== 3 || o.err !== 1'b0) begin
        n_bad++; $display("FAIL load_timing[%0d]: got done %0d err %b required 3/0", i, o.done_cyc, o.err);
      end
    end
  endtask

  task automatic test_store_half();
    res_t e, o;
    poke(16, 32'h11223344);
    model_step(1'b1, F3_H, 32'h42, 32'h0000BEEF, e);
    do_access(1'b1, F3_H, 32'h42, 32'h0000BEEF, o);
    n_cmp++; if (o.wr_cnt !== 1 || o.wr_word !== 32'hBEEF3344 || o.wr_addr !== 12'h040) begin
      n_bad++; $display("FAIL sh_write: got %0d writes %h @%h required 1 BEEF3344 @040", o.wr_cnt, o.wr_word, o.wr_addr);
    end
    n_cmp++; if (o.done_cyc !== 5 || o.err !== 1'b0) begin
      n_bad++; $display("FAIL sh_timing: got done %0d err %b required 5/0", o.done_cyc, o.err);
    end
    model_step(1'b0, F3_W, 32'h40, 32'h0, e);
    do_access(1'b0, F3_W, 32'h40, 32'h0, o);
    n_cmp++; if (o.load !== 32'hBEEF3344 || o.done_cyc !== 3) begin
      n_bad++; $display("FAIL sh_readback: got %h done %0d required BEEF3344 done 3", o.load, o.done_cyc);
    end
  endtask

  task automatic test_store_word();
    res_t e, o;
    model_step(1'b1, F3_W, 32'h44, 32'hDEADBEEF, e);
    do_access(1'b1, F3_W, 32'h44, 32'hDEADBEEF, o);
    n_cmp++; if (o.wr_cnt !== 1 || o.wr_cyc !== 1 || o.wr_word !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_write: got %0d writes cyc %0d data %h required 1 cyc 1 DEADBEEF", o.wr_cnt, o.wr_cyc, o.wr_word);
    end
    n_cmp++; if (o.rd_cnt !== 0 || o.done_cyc !== 3) begin
      n_bad++; $display("FAIL sw_timing: got %0d reads done %0d required 0 reads done 3", o.rd_cnt, o.done_cyc);
    end
  endtask

  task automatic test_misalign();
    res_t e, o;
    logic [31:0] prev;
    prev = m_load;
    model_step(1'b0, F3_W, 32'h46, 32'h0, e);
    do_access(1'b0, F3_W, 32'h46, 32'h0, o);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (o.done_cyc !== 1 || o.err !== 1'b1 || o.rd_cnt !== 0 || o.wr_cnt !== 0 || o.load !== prev) begin
      n_bad++; $display("FAIL lw_misalign: got done %0d err %b rd %0d wr %0d load %h required 1/1/0/0/%h",
                        o.done_cyc, o.err, o.rd_cnt, o.wr_cnt, o.load, prev);
    end
`else
    n_cmp++; if (o.done_cyc !== 3 || o.err !== 1'b0 || o.rd_addr !== 12'h044 || o.load !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL lw_misalign: got done %0d err %b addr %h load %h required 3/0/044/DEADBEEF (prev %h)",
                        o.done_cyc, o.err, o.rd_addr, o.load, prev);
    end
`endif
  endtask

  task automatic test_random();
    res_t e, o;
    bit st;
    logic [2:0]  f3;
    logic [31:0] a, sd;
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom() & 32'hFFFFF0FF;
      sd = $urandom();
      model_step(st, f3, a, sd, e);
      do_access(st, f3, a, sd, o);
      n_cmp++; if (o.done_cyc !== e.done_cyc || o.err !== e.err) begin
        n_bad++; $display("FAIL rnd_done[%0d]: got cyc %0d err %b required cyc %0d err %b (st %b f3 %b a %h)",
                          i, o.done_cyc, o.err, e.done_cyc, e.err, st, f3, a);
      end
      n_cmp++; if (o.rd_cnt !== e.rd_cnt || o.wr_cnt !== e.wr_cnt || o.wr_cyc !== e.wr_cyc) begin
        n_bad++; $display("FAIL rnd_strobes[%0d]: got rd %0d wr %0d@%0d required rd %0d wr %0d@%0d",
                          i, o.rd_cnt, o.wr_cnt, o.wr_cyc, e.rd_cnt, e.wr_cnt, e.wr_cyc);
      end
      if (e.rd_cnt > 0) begin
        n_cmp++; if (o.rd_addr !== e.rd_addr) begin
          n_bad++; $display("FAIL rnd_rd_addr[%0d]: got %h required %h", i, o.rd_addr, e.rd_addr);
        end
      end
      if (e.wr_cnt > 0) begin
        n_cmp++; if (o.wr_word !== e.wr_word || o.wr_addr !== e.wr_addr) begin
          n_bad++; $display("FAIL rnd_write[%0d]: got %h @%h required %h @%h", i, o.wr_word, o.wr_addr, e.wr_word, e.wr_addr);
        end
      end
      n_cmp++; if (o.load !== e.load) begin
        n_bad++; $display("FAIL rnd_load[%0d]: got %h required %h", i, o.load, e.load);
      end
      n_cmp++; if (o.busy_ok !== 1'b1 || o.idle_after !== 1'b1) begin
        n_bad++; $display("FAIL rnd_busy[%0d]: got busy_ok %b idle_after %b required 1 1", i, o.busy_ok, o.idle_after);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    poke(16, 32'h11223344);
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = F3_B; addr = 32'h41; store_data = 32'h000000AA;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    n_cmp++; if (read_enable !== 1'b1) begin
      n_bad++; $display("FAIL sb_rd_before_reset: got %b required 1", read_enable);
    end
    @(negedge clk);
    nRst = 1'b0;
    #1;
    n_cmp++; if ({busy, done, err, read_enable, write_enable, address_DM, data_in, load_data} !== 81'h0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got busy %b done %b err %b re %b we %b addr %h din %h ld %h required all 0",
                        busy, done, err, read_enable, write_enable, address_DM, data_in, load_data);
    end
    m_load = '0;
    @(negedge clk);
    nRst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write_enable === 1'b1) wr_seen++;
    end
    n_cmp++; if (wr_seen !== 0) begin
      n_bad++; $display("FAIL mid_reset_no_write: got %0d writes required 0", wr_seen);
    end
    n_cmp++; if (mem[16] !== 32'h11223344) begin
      n_bad++; $display("FAIL mid_reset_ram: got %h required 11223344", mem[16]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_store_half();
    test_store_word();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
